branch_predictor_gshare_spec: RTL and testbench

//  Parametrised gshare direction predictor with a speculative global history register (GHR),

---
 rtl/branch_predictor_gshare_spec.sv | 123 ++++++++++++
 tb/tb_branch_predictor_gshare_spec.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_spec.sv
// gshare direction predictor: speculative global history, history repair on mispredict
// and a reset-time sweep that loads INIT_COUNTER into every pattern-history entry.
package branch_predictor_gshare_spec_pkg;
    typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} branch_outcome_e;
endpackage

// state | meaning
// INIT  | sweeping INIT_COUNTER into the PHT; requests/feedback ignored, o_ready low
// RUN   | predicting from PHT/GHR, training on feedback, repairing GHR on mispredict
module branch_predictor_gshare_spec
    import branch_predictor_gshare_spec_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_WIDTH = 8,
    parameter int COUNTER_WIDTH = 2,
    parameter logic [COUNTER_WIDTH-1:0] INIT_COUNTER = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output branch_outcome_e       o_req_prediction,
    output logic [HIST_WIDTH-1:0] o_req_ghr,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  logic [HIST_WIDTH-1:0] i_fb_ghr,
    input  branch_outcome_e       i_fb_prediction,
    input  branch_outcome_e       i_fb_outcome
);

    localparam int ENTRIES = 2 ** INDEX_WIDTH;

    typedef enum logic {INIT, RUN} state_e;

    state_e                   state, state_next;
    logic [INDEX_WIDTH-1:0]   sweep_ptr;
    logic [HIST_WIDTH-1:0]    ghr, ghr_next;
    logic [COUNTER_WIDTH-1:0] pht [ENTRIES];

    logic [INDEX_WIDTH-1:0]   req_idx, fb_idx, pht_waddr;
    logic [COUNTER_WIDTH-1:0] fb_count, pht_wdata;
    logic                     pht_we, mispredict, req_taken;
    logic                     unused_pc_bits;

    // Shift a new outcome into the history; the cast keeps it valid for HIST_WIDTH==1.
    function automatic logic [HIST_WIDTH-1:0] shift_in(input logic [HIST_WIDTH-1:0] hist,
                                                       input logic bit_in);
        return HIST_WIDTH'({hist, bit_in});
    endfunction

    assign req_idx    = i_req_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
    assign fb_idx     = i_fb_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(i_fb_ghr);
    assign fb_count   = pht[fb_idx];
    assign req_taken  = pht[req_idx][COUNTER_WIDTH-1];
    assign mispredict = (i_fb_prediction != i_fb_outcome);
    assign o_req_ghr  = ghr;

    // PC bits outside the word-aligned index field do not take part in prediction.
    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_req_pc[1:0],
                              i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_fb_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            sweep_ptr <= '0;
            ghr       <= '0;
        end else begin
            state <= state_next;
            ghr   <= ghr_next;
            if (state == INIT) begin
                sweep_ptr <= sweep_ptr + INDEX_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next       = state;
        ghr_next         = ghr;
        pht_we           = 1'b0;
        pht_waddr        = sweep_ptr;
        pht_wdata        = INIT_COUNTER;
        o_ready          = 1'b0;
        o_req_prediction = NOT_TAKEN;
        case (state)
            INIT: begin
                pht_we = 1'b1;
                if (sweep_ptr == '1) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                o_ready          = 1'b1;
                o_req_prediction = req_taken ? TAKEN : NOT_TAKEN;
                if (i_fb_valid) begin
                    pht_we    = 1'b1;
                    pht_waddr = fb_idx;
                    if (i_fb_outcome == TAKEN) begin
                        pht_wdata = (fb_count == '1) ? fb_count : fb_count + COUNTER_WIDTH'(1);
                    end else begin
                        pht_wdata = (fb_count == '0) ? fb_count : fb_count - COUNTER_WIDTH'(1);
                    end
                end
                // Repair wins: the younger request is squashed upstream.
                if (i_fb_valid && mispredict) begin
                    ghr_next = shift_in(i_fb_ghr, i_fb_outcome == TAKEN);
                end else if (i_req_valid) begin
                    ghr_next = shift_in(ghr, req_taken);
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Single write port, combinational read: same-cycle readers see the old value.
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare_spec.sv
// Randomised and directed bench for branch_predictor_gshare_spec (16-entry PHT, 4-bit GHR)
// checked against an array-based reference model of the gshare rules.
module tb_branch_predictor_gshare_spec;
    import branch_predictor_gshare_spec_pkg::*;

    localparam int IW = 4;
    localparam int HW = 4;
    localparam int CW = 2;
    localparam int AW = 32;
    localparam int ENTRIES = 1 << IW;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            o_ready;
    logic            i_req_valid = 1'b0;
    logic [AW-1:0]   i_req_pc = '0;
    branch_outcome_e o_req_prediction;
    logic [HW-1:0]   o_req_ghr;
    logic            i_fb_valid = 1'b0;
    logic [AW-1:0]   i_fb_pc = '0;
    logic [HW-1:0]   i_fb_ghr = '0;
    branch_outcome_e i_fb_prediction = NOT_TAKEN;
    branch_outcome_e i_fb_outcome = NOT_TAKEN;

    int checks = 0;
    int errors = 0;

    int model_pht [ENTRIES];
    int model_ghr;
    int init_left;

    branch_predictor_gshare_spec #(
        .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .HIST_WIDTH(HW),
        .COUNTER_WIDTH(CW), .INIT_COUNTER(2'b10)
    ) dut (
        .clk(clk), .rst(rst), .o_ready(o_ready),
        .i_req_valid(i_req_valid), .i_req_pc(i_req_pc),
        .o_req_prediction(o_req_prediction), .o_req_ghr(o_req_ghr),
        .i_fb_valid(i_fb_valid), .i_fb_pc(i_fb_pc), .i_fb_ghr(i_fb_ghr),
        .i_fb_prediction(i_fb_prediction), .i_fb_outcome(i_fb_outcome)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] pc, input int hist);
        return int'((pc >> 2) % ENTRIES) ^ hist;
    endfunction

    function automatic void model_reset();
        foreach (model_pht[i]) model_pht[i] = 2;
        model_ghr = 0;
        init_left = ENTRIES;
    endfunction

    // Called at a falling edge: applies inputs, checks outputs, advances the model past one rising edge.
    task automatic drive(input string tag, input logic rv, input logic [AW-1:0] rpc,
                         input logic fv, input logic [AW-1:0] fpc, input logic [HW-1:0] fghr,
                         input logic fpred, input logic fout);
        int exp_pred;
        int fi;
        i_req_valid     = rv;
        i_req_pc        = rpc;
        i_fb_valid      = fv;
        i_fb_pc         = fpc;
        i_fb_ghr        = fghr;
        i_fb_prediction = fpred ? TAKEN : NOT_TAKEN;
        i_fb_outcome    = fout ? TAKEN : NOT_TAKEN;
        #1;
        exp_pred = (init_left == 0 && model_pht[idx_of(rpc, model_ghr)] >= (1 << (CW - 1))) ? 1 : 0;
        check({tag, "_pred"}, int'(o_req_prediction), exp_pred);
        check({tag, "_ghr"}, int'(o_req_ghr), model_ghr);
        check({tag, "_ready"}, int'(o_ready), (init_left == 0) ? 1 : 0);
        if (init_left > 0) begin
            init_left--;
        end else begin
            if (fv) begin
                fi = idx_of(fpc, int'(fghr));
                if (fout) model_pht[fi] = (model_pht[fi] < CMAX) ? model_pht[fi] + 1 : CMAX;
                else      model_pht[fi] = (model_pht[fi] > 0) ? model_pht[fi] - 1 : 0;
            end
            if (fv && fpred != fout) model_ghr = (int'(fghr) * 2 + int'(fout)) % (1 << HW);
            else if (rv)             model_ghr = (model_ghr * 2 + exp_pred) % (1 << HW);
        end
        @(negedge clk);
    endtask

    task automatic drive_random(input string tag);
        drive(tag, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
              HW'($urandom_range(0, (1 << HW) - 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int cycles);
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_fb_valid  = 1'b0;
        #1;
        check("rst_ready", int'(o_ready), 0);
        check("rst_ghr", int'(o_req_ghr), 0);
        check("rst_pred", int'(o_req_prediction), int'(NOT_TAKEN));
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic sweep_and_check(input string tag);
        for (int i = 0; i <= ENTRIES; i++) begin
            check({tag, "_ready_seq"}, int'(o_ready), (i == ENTRIES) ? 1 : 0);
            drive_random(tag);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset, sweep timing, requests ignored while initialising
        do_reset(3);
        sweep_and_check("t1");

        // Reset in the middle of the sweep restarts it
        do_reset(2);
        for (int i = 0; i < 7; i++) drive_random("t2_pre");
        do_reset(2);
        sweep_and_check("t2");

        // Saturating decrement of PHT[0] with repair history 0
        drive("t3a", 1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0);
        drive("t3b", 1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0);
        drive("t3c", 1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b0, 1'b0);
        check("t3_pred_sat", int'(o_req_prediction), int'(NOT_TAKEN));

        // Speculative history: three taken predictions
        drive("t4a", 1'b1, 32'h60, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive("t4b", 1'b1, 32'h60, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive("t4c", 1'b1, 32'h60, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        check("t4_ghr", int'(o_req_ghr), 7);

        // Mispredict repair overrides a same-cycle request shift
        drive("t5", 1'b1, 32'h60, 1'b1, 32'h60, 4'h1, 1'b1, 1'b0);
        check("t5_ghr", int'(o_req_ghr), 2);

        // Same-entry read and write: PHT[5] brought to 01, then trained taken
        drive("t6a", 1'b0, 32'h5C, 1'b1, 32'h54, 4'h0, 1'b0, 1'b0);
        check("t6_pred_before", int'(o_req_prediction), int'(NOT_TAKEN));
        drive("t6b", 1'b0, 32'h5C, 1'b1, 32'h54, 4'h0, 1'b1, 1'b1);
        check("t6_pred_after", int'(o_req_prediction), int'(TAKEN));

        for (int i = 0; i < 400; i++) drive_random("rnd");

        // Reset while running
        do_reset(1);
        sweep_and_check("t7");
        for (int i = 0; i < 50; i++) drive_random("rnd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
